// File: rtl/sser_key_sequencer_if.sv
// Bus-side signals of the SSER serial-ID window: address/strobe from the host,
// serial data and its drive enable back to the host.
interface sser_key_sequencer_if;
  logic       sser;
  logic       ba13;
  logic       ba12;
  logic [3:0] ba7_4;
  logic       br_w;
  logic       bus_stb;
  logic       sdrd;
  logic       sdrd_oe;

  modport master (
    output sser, ba13, ba12, ba7_4, br_w, bus_stb,
    input  sdrd, sdrd_oe
  );

  modport slave (
    input  sser, ba13, ba12, ba7_4, br_w, bus_stb,
    output sdrd, sdrd_oe
  );
endinterface

// File: rtl/sser_key_sequencer.sv
// Knock-sequence gated serial-ID readout: a programmed nibble sequence of reads
// unlocks the block, then each read shifts one (optionally scrambled) ID bit out.
module sser_key_sequencer #(
  parameter int          KEY_LEN  = 4,
  parameter logic [31:0] KEY      = 32'h0000_5A3C,
  parameter int          ID_W     = 16,
  parameter bit          SCRAMBLE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  sser_key_sequencer_if.slave bus,
  input  logic [ID_W-1:0]     id_word,
  output logic                unlocked,
  output logic                done
);

  localparam int KW = $clog2(KEY_LEN) + 1;
  localparam int BW = $clog2(ID_W) + 1;
  localparam logic [KW-1:0] KEY_LAST = KW'(KEY_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(ID_W - 1);

  typedef enum logic [1:0] {KNOCK, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] key_idx, key_idx_nxt;
  logic [BW-1:0] bit_idx, bit_idx_nxt;
  logic [5:0]    lfsr, lfsr_nxt;

  logic       win, qrd, qwr;
  logic [3:0] key_nib;
  logic       id_bit;

  assign win = ~bus.sser & ~bus.ba13 & bus.ba12;
  assign qrd = bus.bus_stb & win & bus.br_w;
  assign qwr = bus.bus_stb & win & ~bus.br_w;

  // Mux selects only in-range indices; out-of-range positions fall back to element 0.
  always_comb begin
    key_nib = KEY[3:0];
    for (int i = 0; i < KEY_LEN; i++) begin
      if (key_idx == KW'(i)) key_nib = KEY[4*i +: 4];
    end
  end

  always_comb begin
    id_bit = id_word[0];
    for (int i = 0; i < ID_W; i++) begin
      if (bit_idx == BW'(i)) id_bit = id_word[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= KNOCK;
      key_idx <= '0;
      bit_idx <= '0;
      lfsr    <= 6'h01;
    end else begin
      state   <= state_nxt;
      key_idx <= key_idx_nxt;
      bit_idx <= bit_idx_nxt;
      lfsr    <= lfsr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    key_idx_nxt = key_idx;
    bit_idx_nxt = bit_idx;
    lfsr_nxt    = lfsr;
    if (qwr) begin
      state_nxt   = KNOCK;
      key_idx_nxt = '0;
      bit_idx_nxt = '0;
      lfsr_nxt    = 6'h01;
    end else if (qrd) begin
      case (state)
        KNOCK: begin
          if (bus.ba7_4 == key_nib) begin
            key_idx_nxt = key_idx + 1'b1;
            if (key_idx == KEY_LAST) begin
              state_nxt   = SHIFT;
              bit_idx_nxt = '0;
              lfsr_nxt    = 6'h01;
            end
          end else begin
            // A broken sequence may itself be the start of a fresh attempt.
            key_idx_nxt = (bus.ba7_4 == KEY[3:0]) ? KW'(1) : '0;
          end
        end
        SHIFT: begin
          bit_idx_nxt = bit_idx + 1'b1;
          lfsr_nxt    = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
          if (bit_idx == BIT_LAST) state_nxt = DONE;
        end
        default: begin
        end
      endcase
    end
  end

  // The bit presented is the one selected before this read's strobe advances it.
  assign bus.sdrd_oe = win & bus.br_w & (state == SHIFT);
  assign bus.sdrd    = bus.sdrd_oe & (id_bit ^ (SCRAMBLE & lfsr[0]));
  assign unlocked    = (state == SHIFT);
  assign done        = (state == DONE);

endmodule
